// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. A three-state
// FSM (IDLE -> EXEC -> RESP) accepts one operation, presents the latched
// operands to the ALU, captures its result, and holds that result until the
// owning requester consumes it. Round-robin arbitration chooses between two
// simultaneous requesters.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req<n>_valid/_ready       request handshake per requester (n = 0, 1)
//   req<n>_op/_a/_b           opcode and operands per requester
//   resp<n>_valid/_ready      response handshake per requester
//   resp_result, resp_zero    registered ALU result and zero flag (shared)
//   alu_op, alu_in_a/_in_b    drive the shared ALU (from latched registers)
//   alu_result, alu_zero      returned by the shared ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,

  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero,

  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_in_a,
  output logic [XLEN-1:0] alu_in_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            last_grant;  // ID of the most recently accepted requester
  logic            gnt_q;       // owner of the in-flight operation
  logic            rst_hold;    // high for the first cycle after reset
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;

  logic            gnt_sel;     // arbitration winner this cycle
  logic            arb_open;    // FSM can accept a new operation
  logic            accept;

  // ALU is fed only from the latched registers so requester input changes
  // never reach it outside an accept.
  assign alu_op   = op_q;
  assign alu_in_a = a_q;
  assign alu_in_b = b_q;

  // Round-robin: a lone requester always wins; under contention the one that
  // did not win last time goes next.
  always_comb begin
    gnt_sel = 1'b0;
    if (req0_valid && req1_valid)
      gnt_sel = ~last_grant;
    else if (req1_valid)
      gnt_sel = 1'b1;
  end

  // Readies are gated by rst and by the post-reset cycle so nothing is
  // accepted while reset is asserted or in the cycle directly after it.
  always_comb begin
    arb_open   = (state == IDLE) && !rst && !rst_hold;
    req0_ready = arb_open && req0_valid && !gnt_sel;
    req1_ready = arb_open && req1_valid &&  gnt_sel;
    accept     = req0_ready || req1_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;      // requester 0 wins the first contention
      gnt_q       <= 1'b0;
      rst_hold    <= 1'b1;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      rst_hold <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= gnt_sel ? req1_op : req0_op;
            a_q        <= gnt_sel ? req1_a  : req0_a;
            b_q        <= gnt_sel ? req1_b  : req0_b;
            gnt_q      <= gnt_sel;
            last_grant <= gnt_sel;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // ALU is combinational on op_q/a_q/b_q, settled by this edge.
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          resp0_valid <= !gnt_q;
          resp1_valid <=  gnt_q;
          state       <= RESP;
        end
        RESP: begin
          // Only the owner's ready releases the response; the other port's
          // ready is ignored.
          if (gnt_q ? resp1_ready : resp0_ready) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          resp0_valid <= 1'b0;
          resp1_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
